// File: rtl/dmac_mi_arbiter.sv
// Master-interface arbiter: picks the highest-priority channel request (round-robin on ties), requests the AHB bus and holds an optional bus lock.
// Latency: grant_mi and hbusreq assert 2 cycles after a request reaches an idle arbiter.
// Backpressure: the grant is held until hgrant arrives and xfer_done completes the block; new requests wait for the next IDLE.
module dmac_mi_arbiter #(
  parameter int         NUM_CH     = 8,
  parameter int         PRI_W      = 3,
  parameter logic [1:0] MASTER_NUM = 2'b00
) (
  input  logic                    hclk,
  input  logic                    hreset,
  input  logic [NUM_CH-1:0]       req_mi,
  input  logic [NUM_CH*PRI_W-1:0] ch_prior,
  input  logic [NUM_CH-1:0]       lock_req,
  input  logic                    hgrant,
  input  logic                    xfer_done,
  output logic [NUM_CH-1:0]       grant_mi,
  output logic [NUM_CH-1:0]       mask_lck_ch,
  output logic                    hbusreq,
  output logic                    hlock,
  output logic [1:0]              mi_id
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARB    = 2'd1,
    BUSREQ = 2'd2,
    XFER   = 2'd3
  } state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   winner_q;
  logic [IDX_W-1:0]   rr_ptr;
  logic [NUM_CH-1:0]  grant_q;
  logic [NUM_CH-1:0]  mask_q;
  logic               lock_q;

  logic               owner_req;
  logic [NUM_CH-1:0]  eff_mask;
  logic [NUM_CH-1:0]  eff_req;
  logic [IDX_W-1:0]   arb_idx;
  logic [PRI_W-1:0]   arb_pri;
  logic               arb_found;
  logic [NUM_CH-1:0]  arb_onehot;

  // A locked owner that has stopped requesting no longer shields the other lines.
  assign owner_req = req_mi[winner_q];
  assign eff_mask  = (lock_q && owner_req) ? mask_q : '0;
  assign eff_req   = req_mi & ~eff_mask;

  // Scan starts just after the last winner so equal priorities rotate.
  always_comb begin
    arb_idx   = '0;
    arb_pri   = '0;
    arb_found = 1'b0;
    for (int k = 1; k <= NUM_CH; k++) begin
      int cand;
      cand = int'(rr_ptr) + k;
      if (cand >= NUM_CH) cand = cand - NUM_CH;
      if (eff_req[cand] && (!arb_found || (ch_prior[cand*PRI_W +: PRI_W] > arb_pri))) begin
        arb_found = 1'b1;
        arb_idx   = IDX_W'(cand);
        arb_pri   = ch_prior[cand*PRI_W +: PRI_W];
      end
    end
  end

  assign arb_onehot = NUM_CH'(1) << arb_idx;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|eff_req) state_nxt = ARB;
      ARB:     state_nxt = arb_found ? BUSREQ : IDLE;
      BUSREQ: begin
        if (hgrant)          state_nxt = XFER;
        else if (!owner_req) state_nxt = IDLE;
      end
      XFER:    if (xfer_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      winner_q <= '0;
      rr_ptr   <= IDX_W'(NUM_CH - 1);
      grant_q  <= '0;
      mask_q   <= '0;
      lock_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (lock_q && !owner_req) begin
            lock_q <= 1'b0;
            mask_q <= '0;
          end
        end
        ARB: begin
          if (arb_found) begin
            winner_q <= arb_idx;
            rr_ptr   <= arb_idx;
            grant_q  <= arb_onehot;
            lock_q   <= lock_req[arb_idx];
            mask_q   <= lock_req[arb_idx] ? ~arb_onehot : '0;
          end
        end
        BUSREQ: begin
          if (!hgrant && !owner_req) begin
            grant_q <= '0;
            lock_q  <= 1'b0;
            mask_q  <= '0;
          end
        end
        XFER: begin
          if (xfer_done) begin
            grant_q <= '0;
            if (!lock_req[winner_q]) begin
              lock_q <= 1'b0;
              mask_q <= '0;
            end
          end
        end
        default: begin
          grant_q <= '0;
        end
      endcase
    end
  end

  assign grant_mi    = grant_q;
  assign mask_lck_ch = mask_q;
  assign hbusreq     = (state == BUSREQ) || (state == XFER);
  assign hlock       = lock_q;
  assign mi_id       = MASTER_NUM;

endmodule

// File: tb/tb_dmac_mi_arbiter.sv
// Directed bench for dmac_mi_arbiter: expected grants are queued with the stimulus and checked by a monitor on each new grant.
module tb_dmac_mi_arbiter;
  localparam int N  = 8;
  localparam int PW = 3;

  logic            hclk = 1'b0;
  logic            hreset = 1'b1;
  logic [N-1:0]    req_mi = '0;
  logic [N*PW-1:0] ch_prior = '0;
  logic [N-1:0]    lock_req = '0;
  logic            hgrant = 1'b0;
  logic            xfer_done = 1'b0;
  logic [N-1:0]    grant_mi;
  logic [N-1:0]    mask_lck_ch;
  logic            hbusreq;
  logic            hlock;
  logic [1:0]      mi_id;

  typedef struct packed {
    logic [7:0] g;
    logic [7:0] m;
    logic       l;
  } exp_t;

  exp_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] prev_g = '0;

  dmac_mi_arbiter #(.NUM_CH(N), .PRI_W(PW), .MASTER_NUM(2'b00)) dut (
    .hclk        (hclk),
    .hreset      (hreset),
    .req_mi      (req_mi),
    .ch_prior    (ch_prior),
    .lock_req    (lock_req),
    .hgrant      (hgrant),
    .xfer_done   (xfer_done),
    .grant_mi    (grant_mi),
    .mask_lck_ch (mask_lck_ch),
    .hbusreq     (hbusreq),
    .hlock       (hlock),
    .mi_id       (mi_id)
  );

  always #5 hclk = ~hclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge hclk);
    #1;
  endtask

  task automatic push(input logic [7:0] g, input logic [7:0] m, input logic l);
    exp_t e;
    e.g = g;
    e.m = m;
    e.l = l;
    exp_q.push_back(e);
  endtask

  task automatic set_pri(input int all, input int idx, input int val);
    for (int i = 0; i < N; i++) ch_prior[i*PW +: PW] = PW'(all);
    if (idx >= 0) ch_prior[idx*PW +: PW] = PW'(val);
  endtask

  // From BUSREQ: take the bus, then complete the block.
  task automatic finish_xfer(input bit clr);
    hgrant = 1'b1;
    tick(1);
    hgrant = 1'b0;
    xfer_done = 1'b1;
    if (clr) req_mi = '0;
    tick(1);
    xfer_done = 1'b0;
  endtask

  always @(negedge hclk) begin
    if (hreset === 1'b0 && grant_mi !== '0 && prev_g === '0) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: grant %0h with no expected entry", grant_mi);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_grant", 32'(grant_mi), 32'(e.g));
        chk("sb_mask", 32'(mask_lck_ch), 32'(e.m));
        chk("sb_hlock", 32'(hlock), 32'(e.l));
      end
    end
    prev_g = grant_mi;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    tick(3);
    chk("rst_grant", 32'(grant_mi), 32'h0);
    chk("rst_mask", 32'(mask_lck_ch), 32'h0);
    chk("rst_hbusreq", 32'(hbusreq), 32'h0);
    chk("rst_hlock", 32'(hlock), 32'h0);
    chk("mi_id", 32'(mi_id), 32'h0);
    hreset = 1'b0;

    // Equal priorities: line 0 wins first, then round-robin moves to line 2.
    set_pri(0, -1, 0);
    push(8'h01, 8'h00, 1'b0);
    req_mi = 8'h05;
    tick(2);
    chk("lat_grant", 32'(grant_mi), 32'h01);
    chk("lat_hbusreq", 32'(hbusreq), 32'h1);
    push(8'h04, 8'h00, 1'b0);
    hgrant = 1'b1;
    tick(1);
    hgrant = 1'b0;
    xfer_done = 1'b1;
    tick(1);
    xfer_done = 1'b0;
    chk("done_hbusreq", 32'(hbusreq), 32'h0);
    chk("done_grant", 32'(grant_mi), 32'h0);
    tick(2);
    chk("rr_grant", 32'(grant_mi), 32'h04);
    finish_xfer(1'b1);

    // Priority beats round-robin order.
    set_pri(0, 7, 5);
    ch_prior[0 +: PW] = 3'd2;
    push(8'h80, 8'h00, 1'b0);
    req_mi = 8'h81;
    tick(2);
    finish_xfer(1'b1);

    // Lock held by line 3 across two completions, released at the third.
    set_pri(1, 3, 6);
    lock_req = 8'h08;
    push(8'h08, 8'hF7, 1'b1);
    req_mi = 8'h0F;
    tick(2);
    chk("lock_mask", 32'(mask_lck_ch), 32'hF7);
    chk("lock_hlock", 32'(hlock), 32'h1);
    for (int i = 0; i < 2; i++) begin
      push(8'h08, 8'hF7, 1'b1);
      finish_xfer(1'b0);
      chk("lock_persist", 32'(hlock), 32'h1);
      tick(2);
      chk("lock_regrant", 32'(grant_mi), 32'h08);
    end
    push(8'h08, 8'h00, 1'b0);
    lock_req = 8'h00;
    finish_xfer(1'b0);
    chk("unlock_mask", 32'(mask_lck_ch), 32'h0);
    chk("unlock_hlock", 32'(hlock), 32'h0);
    tick(2);
    finish_xfer(1'b1);

    // Locked owner stops requesting in IDLE: lock drops, line 0 gets the bus.
    lock_req = 8'h08;
    push(8'h08, 8'hF7, 1'b1);
    req_mi = 8'h0F;
    tick(2);
    push(8'h01, 8'h00, 1'b0);
    hgrant = 1'b1;
    tick(1);
    hgrant = 1'b0;
    xfer_done = 1'b1;
    req_mi = 8'h07;
    tick(1);
    xfer_done = 1'b0;
    tick(1);
    chk("idle_rel_mask", 32'(mask_lck_ch), 32'h0);
    chk("idle_rel_hlock", 32'(hlock), 32'h0);
    lock_req = 8'h00;
    tick(1);
    finish_xfer(1'b1);

    // Winner drops its request before hgrant.
    set_pri(0, -1, 0);
    push(8'h02, 8'h00, 1'b0);
    req_mi = 8'h02;
    tick(2);
    req_mi = 8'h00;
    tick(1);
    chk("abort_hbusreq", 32'(hbusreq), 32'h0);
    chk("abort_grant", 32'(grant_mi), 32'h0);
    tick(1);
    chk("abort_idle", 32'(hbusreq), 32'h0);

    // Stray xfer_done pulses in IDLE and BUSREQ.
    xfer_done = 1'b1;
    tick(1);
    xfer_done = 1'b0;
    chk("stray_idle_hbusreq", 32'(hbusreq), 32'h0);
    push(8'h04, 8'h00, 1'b0);
    req_mi = 8'h0C;
    tick(2);
    xfer_done = 1'b1;
    tick(1);
    xfer_done = 1'b0;
    chk("stray_busreq_hbusreq", 32'(hbusreq), 32'h1);
    chk("stray_busreq_grant", 32'(grant_mi), 32'h04);
    push(8'h08, 8'h00, 1'b0);
    finish_xfer(1'b0);
    tick(2);
    chk("stray_rr_grant", 32'(grant_mi), 32'h08);
    finish_xfer(1'b1);

    // Reset in XFER with a lock held, then a fresh tie goes to line 0.
    lock_req = 8'h01;
    push(8'h01, 8'hFE, 1'b1);
    req_mi = 8'h01;
    tick(2);
    hgrant = 1'b1;
    tick(1);
    hgrant = 1'b0;
    chk("xfer_hlock", 32'(hlock), 32'h1);
    hreset = 1'b1;
    tick(1);
    chk("mid_rst_grant", 32'(grant_mi), 32'h0);
    chk("mid_rst_mask", 32'(mask_lck_ch), 32'h0);
    chk("mid_rst_hbusreq", 32'(hbusreq), 32'h0);
    chk("mid_rst_hlock", 32'(hlock), 32'h0);
    hreset = 1'b0;
    lock_req = 8'h00;
    push(8'h01, 8'h00, 1'b0);
    req_mi = 8'h03;
    tick(2);
    chk("post_rst_grant", 32'(grant_mi), 32'h01);
    finish_xfer(1'b1);

    tick(3);
    chk("sb_drained", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
